// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY,
    RESP
  } arbState_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  function automatic arbState_t busyFor(
    input logic gnt
  );
    return (gnt == GNT_D) ? DBUSY : IBUSY;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data ports.
// MEM_ARB_RR_EN: alternate on ties instead of fixed data priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic iReq,
  input  logic dReq,
  input  logic lastGrant,
  output logic grant,
  output logic anyReq
);

  always_comb begin
    anyReq = iReq | dReq;
    grant  = lastGrant;
`ifdef MEM_ARB_RR_EN
    unique case (1'b1)
      iReq & dReq:  grant = ~lastGrant;
      dReq & ~iReq: grant = GNT_D;
      iReq & ~dReq: grant = GNT_I;
      default:      grant = lastGrant;
    endcase
`else
    unique case (1'b1)
      dReq:         grant = GNT_D;
      iReq & ~dReq: grant = GNT_I;
      default:      grant = lastGrant;
    endcase
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and data ports.
// Optional round-robin tie break: MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_rdy
);

  arbState_t     stateQ, stateD;
  logic          lastGrantQ, lastGrantD;
  logic          mReqD, mWeD;
  logic [AW-1:0] mAddrD;
  logic [DW-1:0] mWdataD;
  logic [DW-1:0] iRdataD, dRdataD;
  logic          iAckD, dAckD;
  logic          pickGrant, anyReq;

  mem_arb_pick uPick (
    .iReq      (i_req),
    .dReq      (d_req),
    .lastGrant (lastGrantQ),
    .grant     (pickGrant),
    .anyReq    (anyReq)
  );

  always_comb begin
    stateD     = stateQ;
    lastGrantD = lastGrantQ;
    mReqD      = m_req;
    mWeD       = m_we;
    mAddrD     = m_addr;
    mWdataD    = m_wdata;
    iRdataD    = i_rdata;
    dRdataD    = d_rdata;
    iAckD      = 1'b0;
    dAckD      = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (anyReq) begin
          stateD     = busyFor(pickGrant);
          lastGrantD = pickGrant;
          mReqD      = 1'b1;
          if (pickGrant == GNT_D) begin
            mAddrD  = d_addr;
            mWeD    = d_we;
            mWdataD = d_wdata;
          end else begin
            mAddrD  = i_addr;
            mWeD    = 1'b0;
            mWdataD = '0;
          end
        end
      end
      IBUSY: begin
        if (m_rdy) begin
          iRdataD = m_rdata;
          iAckD   = 1'b1;
          mReqD   = 1'b0;
          mWeD    = 1'b0;
          stateD  = RESP;
        end
      end
      DBUSY: begin
        if (m_rdy) begin
          // stores leave the last load value visible
          if (!m_we) dRdataD = m_rdata;
          dAckD  = 1'b1;
          mReqD  = 1'b0;
          mWeD   = 1'b0;
          stateD = RESP;
        end
      end
      RESP: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= IDLE;
      lastGrantQ <= GNT_I;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      lastGrantQ <= lastGrantD;
      m_req      <= mReqD;
      m_we       <= mWeD;
      m_addr     <= mAddrD;
      m_wdata    <= mWdataD;
      i_rdata    <= iRdataD;
      d_rdata    <= dRdataD;
      i_ack      <= iAckD;
      d_ack      <= dAckD;
    end
  end

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory.
// Also valid with MEM_ARB_RR_EN defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_rdy;

  int checks;
  int failures;

  int memWait;
  bit randWait;
  int waitLeft;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];

  bit monOn;
  int ackCntI;
  int ackCntD;
  logic prevReq;
  logic prevWe;
  logic [31:0] prevAddr;
  logic [31:0] prevWdata;

  mem_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .i_stall (i_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .d_stall (d_stall),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_rdy   (m_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // memory: m_rdy after memWait (or random 0-7) cycles of m_req
  initial begin
    m_rdy = 1'b0;
    m_rdata = '0;
    waitLeft = -1;
    forever begin
      @(negedge clk);
      if (!rst || !m_req) begin
        m_rdy = 1'b0;
        waitLeft = -1;
      end else if (!m_rdy) begin
        if (waitLeft < 0)
          waitLeft = randWait ? int'($urandom_range(0, 7)) : memWait;
        if (waitLeft == 0) begin
          m_rdy = 1'b1;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            m_rdata = $urandom;
          end else begin
            m_rdata = mem.exists(m_addr) ? mem[m_addr] : defaultWord(m_addr);
          end
        end else begin
          waitLeft--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (monOn) begin
      if (i_ack) ackCntI++;
      if (d_ack) ackCntD++;
      checks++;
      if ((i_ack && d_ack) || (m_req && (i_ack || d_ack))) begin
        failures++;
        $display("FAIL mon_ack_excl i_ack=%0b d_ack=%0b m_req=%0b", i_ack, d_ack, m_req);
      end
      if (prevReq && m_req) begin
        checks++;
        if (m_addr !== prevAddr || m_we !== prevWe || m_wdata !== prevWdata) begin
          failures++;
          $display("FAIL mon_stable addr=%h/%h we=%0b/%0b wdata=%h/%h",
                   m_addr, prevAddr, m_we, prevWe, m_wdata, prevWdata);
        end
      end
    end
    prevReq = m_req;
    prevAddr = m_addr;
    prevWe = m_we;
    prevWdata = m_wdata;
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || m_we !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 ||
        m_addr !== 32'h0 || m_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_vals m_req=%0b m_we=%0b acks=%0b%0b m_addr=%h m_wdata=%h rdata=%h/%h (want all 0)",
               m_req, m_we, i_ack, d_ack, m_addr, m_wdata, i_rdata, d_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    mem[32'h40] = 32'h2002_0005;
    memWait = 0;
    @(negedge clk);
    i_addr = 32'h40;
    i_req = 1'b1;
    #1;
    checks++;
    if (i_stall !== 1'b1 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c0 i_stall=%0b m_req=%0b (want 1 0)", i_stall, m_req);
    end
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0 || i_ack !== 1'b0 || i_stall !== 1'b1) begin
      failures++;
      $display("FAIL fetch_c1 m_req=%0b m_addr=%h m_we=%0b i_ack=%0b i_stall=%0b (want 1 40 0 0 1)",
               m_req, m_addr, m_we, i_ack, i_stall);
    end
    @(negedge clk);
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h2002_0005 || i_stall !== 1'b0 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_c2 i_ack=%0b i_rdata=%h i_stall=%0b m_req=%0b (want 1 20020005 0 0)",
               i_ack, i_rdata, i_stall, m_req);
    end
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (i_ack !== 1'b0 || i_stall !== 1'b0 || i_rdata !== 32'h2002_0005) begin
      failures++;
      $display("FAIL fetch_c3 i_ack=%0b i_stall=%0b i_rdata=%h (want 0 0 20020005)",
               i_ack, i_stall, i_rdata);
    end
  endtask

  task automatic test_load_store();
    int reqCycles;
    int acks;
    bit got;
    logic [31:0] atAck;
    mem[32'h54] = 32'hDEAD_BEEF;
    memWait = 3;
    reqCycles = 0;
    acks = 0;
    atAck = '0;
    @(negedge clk);
    d_addr = 32'h54;
    d_we = 1'b0;
    d_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (d_stall !== 1'b1) begin
          failures++;
          $display("FAIL load_stall d_stall=%0b (want 1)", d_stall);
        end
      end
      if (m_req) reqCycles++;
      if (d_ack) begin
        acks++;
        atAck = d_rdata;
        d_req = 1'b0;
      end
    end
    checks++;
    if (reqCycles != 4 || acks != 1 || atAck !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_wait m_req_cycles=%0d acks=%0d d_rdata=%h (want 4 1 deadbeef)",
               reqCycles, acks, atAck);
    end
    memWait = 0;
    @(negedge clk);
    d_we = 1'b1;
    d_wdata = 32'h1234_5678;
    d_req = 1'b1;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'h1234_5678 || m_addr !== 32'h54) begin
      failures++;
      $display("FAIL store_bus m_req=%0b m_we=%0b m_wdata=%h m_addr=%h (want 1 1 12345678 54)",
               m_req, m_we, m_wdata, m_addr);
    end
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || d_rdata !== 32'hDEAD_BEEF || m_we !== 1'b0) begin
      failures++;
      $display("FAIL store_ack got=%0b d_rdata=%h m_we=%0b (want 1 deadbeef 0)", got, d_rdata, m_we);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_both();
    bit seq[$];
    int overlap;
    memWait = 1;
    overlap = 0;
    @(negedge clk);
    i_addr = 32'h10;
    d_addr = 32'h80;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) overlap++;
      if (d_ack) begin
        seq.push_back(1'b1);
        d_req = 1'b0;
      end
      if (i_ack) begin
        seq.push_back(1'b0);
        i_req = 1'b0;
      end
    end
    checks++;
    if (seq.size() != 2 || overlap != 0) begin
      failures++;
      $display("FAIL both_count acks=%0d overlap=%0d (want 2 0)", seq.size(), overlap);
    end else begin
      checks++;
      if (seq[0] !== 1'b1 || seq[1] !== 1'b0) begin
        failures++;
        $display("FAIL both_order first_is_d=%0b second_is_d=%0b (want 1 0)", seq[0], seq[1]);
      end
    end
    checks++;
    if (i_rdata !== defaultWord(32'h10) || d_rdata !== defaultWord(32'h80)) begin
      failures++;
      $display("FAIL both_data i_rdata=%h d_rdata=%h (want %h %h)",
               i_rdata, d_rdata, defaultWord(32'h10), defaultWord(32'h80));
    end
  endtask

  // both requests held through four accesses; last grant before this was I
  task automatic test_back_to_back();
    bit seq[$];
    bit prevD;
    bit expD;
    memWait = 0;
    prevD = 1'b0;
    @(negedge clk);
    i_addr = 32'h14;
    d_addr = 32'h88;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      @(negedge clk);
      if (d_ack) seq.push_back(1'b1);
      if (i_ack) seq.push_back(1'b0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (seq.size() != 4) begin
      failures++;
      $display("FAIL b2b_count acks=%0d (want 4)", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      expD = ~prevD;
`else
      expD = 1'b1;
`endif
      checks++;
      if (seq[k] !== expD) begin
        failures++;
        $display("FAIL b2b_order idx=%0d is_d=%0b (want %0b)", k, seq[k], expD);
      end
      prevD = seq[k];
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    memWait = 20;
    @(negedge clk);
    d_addr = 32'h84;
    d_we = 1'b0;
    d_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy m_req=%0b (want 1)", m_req);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (m_req !== 1'b0 || m_we !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 ||
        m_addr !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_vals m_req=%0b m_we=%0b acks=%0b%0b m_addr=%h rdata=%h/%h (want all 0)",
               m_req, m_we, i_ack, d_ack, m_addr, i_rdata, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    memWait = 1;
    @(negedge clk);
    i_addr = 32'h20;
    i_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || i_rdata !== defaultWord(32'h20)) begin
      failures++;
      $display("FAIL rstmid_after got=%0b i_rdata=%h (want 1 %h)", got, i_rdata, defaultWord(32'h20));
    end
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic reqI(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      bit got;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      a = 32'h200 + ($urandom_range(0, 63) << 2);
      i_addr = a;
      i_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (i_ack) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rand_i_timeout idx=%0d addr=%h", k, a);
      end else if (i_rdata !== defaultWord(a)) begin
        failures++;
        $display("FAIL rand_i_data addr=%h i_rdata=%h (want %h)", a, i_rdata, defaultWord(a));
      end
      i_req = 1'b0;
    end
  endtask

  task automatic reqD(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] expV;
      logic we;
      bit got;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      a = 32'h300 + ($urandom_range(0, 15) << 2);
      we = 1'($urandom_range(0, 1));
      w = $urandom;
      expV = we ? d_rdata : (refMem.exists(a) ? refMem[a] : defaultWord(a));
      d_addr = a;
      d_we = we;
      d_wdata = w;
      d_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (d_ack) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rand_d_timeout idx=%0d addr=%h", k, a);
      end else if (d_rdata !== expV) begin
        failures++;
        $display("FAIL rand_d_data we=%0b addr=%h d_rdata=%h (want %h)", we, a, d_rdata, expV);
      end
      if (we) refMem[a] = w;
      d_req = 1'b0;
      d_we = 1'b0;
    end
  endtask

  task automatic test_random();
    ackCntI = 0;
    ackCntD = 0;
    randWait = 1'b1;
    @(negedge clk);
    monOn = 1'b1;
    fork
      reqI(500);
      reqD(500);
    join
    repeat (4) @(negedge clk);
    monOn = 1'b0;
    randWait = 1'b0;
    checks++;
    if (ackCntI != 500 || ackCntD != 500) begin
      failures++;
      $display("FAIL rand_ack_count i_acks=%0d d_acks=%0d (want 500 500)", ackCntI, ackCntD);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    monOn = 1'b0;
    randWait = 1'b0;
    memWait = 0;
    rst = 1'b0;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    test_reset();
    test_fetch();
    test_load_store();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates one single-port memory between the pipeline's instruction-fetch port and data (mem-stage) port, for the unified-memory build of the 5-stage MIPS core. Each port makes a level request and holds it until a one-cycle ack. A 4-state FSM sequences each transaction against a variable-latency memory handshake. The block generates per-port stall signals that feed the hazard unit (stallF / stall of M and earlier stages).

Parameters:
AW, 32, address width (byte address, passed through unmodified)
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
i_req  in  1  fetch request, level, held until i_ack
i_addr  in  AW  fetch address, stable while i_req
i_rdata  out  DW  fetched instruction, valid in i_ack cycle and held after
i_ack  out  1  one-cycle completion pulse, fetch port
i_stall  out  1  i_req & ~i_ack
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid in d_ack cycle and held after
d_ack  out  1  one-cycle completion pulse, data port
d_stall  out  1  d_req & ~d_ack
m_req  out  1  memory request, held high until m_rdy
m_we  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid with m_rdy
m_rdy  in  1  memory completion, sampled only while m_req=1

Behaviour:
- Reset (rst=0, async): state=IDLE; m_req, m_we, i_ack, d_ack = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; last_grant = I.
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE: with no request, stay. Otherwise grant. Data beats instruction (the M-stage op is older). At the grant edge, register m_addr/m_we/m_wdata from the granted port, set m_req=1 and last_grant, and go to IBUSY or DBUSY.
- IBUSY/DBUSY: m_req=1 and m_addr/m_we/m_wdata stay stable. If m_rdy=0, stay; there is no timeout.
- On m_rdy=1 at the clock edge:
  - capture m_rdata into i_rdata (IBUSY), or into d_rdata (DBUSY, loads only; on stores d_rdata keeps its old value);
  - m_req=0, m_we=0; pulse the matching ack for the next cycle; go to RESP.
- RESP: exactly one ack is high for one cycle. No new grant occurs in this cycle, because the requester's req is still high. Next state is IDLE.
- Minimum latency, request seen in cycle 0: m_req=1 in cycle 1; with m_rdy in cycle 1, ack in cycle 2; next grant possible at the end of cycle 3. Occupancy is 3 cycles per access plus (memory wait cycles).
- Outputs m_*, acks and rdata are all registered. Only the stalls are combinational.
- Deasserting a req before its ack is illegal. The arbiter finishes the granted access anyway and still pulses ack.
- Both reqs in IDLE: data is granted first and instruction is granted in the next IDLE; instruction is never lost.
- Reset mid-transaction: immediate return to reset values. The memory must tolerate an aborted m_req.
- i_ack and d_ack are never high together. m_req is never high in IDLE or RESP.

Optional Feature:
Macro MEM_ARB_RR_EN.
- Defined: on a tie in IDLE, grant the port that is not last_grant (round-robin). The first tie after reset goes to data.
- Undefined: fixed data priority, and last_grant is unused.
- Single-request behaviour is identical either way.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, IBUSY, DBUSY, RESP);
  - grant constants GNT_I=1'b0, GNT_D=1'b1;
  - default AW/DW constants.
- One natural sub-module, mem_arb_pick: combinational grant selection from i_req, d_req and last_grant, holding the MEM_ARB_RR_EN ifdef.
- FSM and registers stay in mem_arbiter.

Test Plan:
- Reset then i_req=1, i_addr=0x0000_0040; memory returns 0x2002_0005 with 0 wait → m_req cycle 1, i_ack cycle 2 with i_rdata=0x2002_0005, i_stall low only in cycle 2.
- d_req load at 0x0000_0054, memory 3 wait cycles, m_rdata=0xDEAD_BEEF → m_req high 4 cycles, d_ack once, d_rdata=0xDEAD_BEEF; then store 0x0000_0054/0x1234_5678 → m_we=1, m_wdata=0x1234_5678, d_rdata stays 0xDEAD_BEEF.
- i_req and d_req raised same cycle (addrs 0x10, 0x80) → grant order D then I, each ack once, no overlap.
- Both reqs held continuously for 4 accesses → without macro: D,D,D,D; with MEM_ARB_RR_EN: D,I,D,I.
- rst to 0 while DBUSY with m_rdy=0 → m_req, acks, rdata = 0 immediately; after release, a new i_req completes normally.
- Random m_rdy delays 0-7 over 1000 accesses → i_ack & d_ack never both high, m_addr stable while m_req, every request acked exactly once.
